status_flag_unit: RTL and testbench

//  Producer side of the NZCV condition flags consumed by the condition checker in ID.

---
 rtl/status_flag_unit_pkg.sv | 39 +++
 rtl/status_flag_unit_flag_reg.sv | 17 +
 rtl/status_flag_unit.sv | 56 +++++
 tb/tb_status_flag_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/status_flag_unit_pkg.sv
// Shared NZCV definitions used by the flag producer and the ID-stage condition checker.
// All 4-bit flag buses are packed {C,N,V,Z}.
package status_flag_unit_pkg;

  typedef logic [3:0] status_t;

  localparam int FLG_C = 3;
  localparam int FLG_N = 2;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 0;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  function automatic status_t pack_flags(input logic c, input logic n,
                                         input logic v, input logic z);
    status_t s;
    s        = '0;
    s[FLG_C] = c;
    s[FLG_N] = n;
    s[FLG_V] = v;
    s[FLG_Z] = z;
    return s;
  endfunction

endpackage

// File: rtl/status_flag_unit_flag_reg.sv
// 4-bit architectural flag register with async active-high clear and load enable.
module flag_reg
  import status_flag_unit_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  status_t d,
  output status_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/status_flag_unit.sv
// NZCV producer: commits ALU flags for S-bit instructions, and feeds the ID condition
// checker either committed or forwarded flags, or raises a flag hazard when not forwarding.
module status_flag_unit
  import status_flag_unit_pkg::*;
#(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exe_valid,
  input  logic             exe_s,
  input  status_t          alu_status,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [3:0]       id_cond,
  output status_t          status,
  output status_t          id_status,
  output logic             flag_hazard,
  output logic [CNT_W-1:0] upd_cnt
);

  logic pend;
  logic upd;
  logic uses;

  assign pend = exe_valid & exe_s & ~flush;
  assign upd  = pend & ~freeze;
  assign uses = id_valid & (id_cond != COND_AL);

  flag_reg u_flag_reg (
    .clk (clk),
    .rst (rst),
    .en  (upd),
    .d   (alu_status),
    .q   (status)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      upd_cnt <= '0;
    else if (upd) upd_cnt <= upd_cnt + 1'b1;
  end

  // Combinational outputs are forced quiet while reset is held, even with a live EXE write.
  generate
    if (FWD_EN) begin : g_fwd
      assign id_status   = rst ? '0 : (pend ? alu_status : status);
      assign flag_hazard = 1'b0;
    end else begin : g_stall
      assign id_status   = rst ? '0 : status;
      assign flag_hazard = ~rst & pend & uses;
    end
  endgenerate

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench: one forwarding instance (CNT_W=16) and one stalling instance (CNT_W=4)
// share the same stimulus; expected values are hand-computed per step.
module tb_status_flag_unit;
  import status_flag_unit_pkg::*;

  logic       clk;
  logic       rst;
  logic       exe_valid;
  logic       exe_s;
  status_t    alu_status;
  logic       freeze;
  logic       flush;
  logic       id_valid;
  logic [3:0] id_cond;

  status_t     f_status, f_id_status;
  logic        f_hazard;
  logic [15:0] f_cnt;
  status_t     s_status, s_id_status;
  logic        s_hazard;
  logic [3:0]  s_cnt;

  int n_checks = 0;
  int n_errors = 0;

  status_flag_unit #(.FWD_EN(1'b1), .CNT_W(16)) dut_fwd (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_s(exe_s),
    .alu_status(alu_status), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_cond(id_cond), .status(f_status),
    .id_status(f_id_status), .flag_hazard(f_hazard), .upd_cnt(f_cnt)
  );

  status_flag_unit #(.FWD_EN(1'b0), .CNT_W(4)) dut_stall (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_s(exe_s),
    .alu_status(alu_status), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_cond(id_cond), .status(s_status),
    .id_status(s_id_status), .flag_hazard(s_hazard), .upd_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input status_t exp_status, input int exp_cnt);
    check({tag, " fwd status"},   16'(f_status), 16'(exp_status));
    check({tag, " stall status"}, 16'(s_status), 16'(exp_status));
    check({tag, " fwd cnt"},      f_cnt,         16'(exp_cnt % 65536));
    check({tag, " stall cnt"},    16'(s_cnt),    16'(exp_cnt % 16));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exe(input logic v, input logic s, input status_t a,
                         input logic frz, input logic fl);
    exe_valid  = v;
    exe_s      = s;
    alu_status = a;
    freeze     = frz;
    flush      = fl;
  endtask

  status_t pat;

  initial begin
    rst = 1'b1;
    set_exe(1'b1, 1'b1, 4'b1011, 1'b0, 1'b0);
    id_valid = 1'b1;
    id_cond  = COND_EQ;
    #1;
    check_state("reset", 4'b0000, 0);
    check("reset fwd id_status",   16'(f_id_status), 16'h0);
    check("reset stall id_status", 16'(s_id_status), 16'h0);
    check("reset stall hazard",    16'(s_hazard),    16'h0);
    check("reset fwd hazard",      16'(f_hazard),    16'h0);

    // Plain S-instruction update
    @(negedge clk);
    rst = 1'b0;
    set_exe(1'b1, 1'b1, 4'b1001, 1'b0, 1'b0);
    id_valid = 1'b0;
    #1;
    check("pre-edge fwd id_status",   16'(f_id_status), 16'b1001);
    check("pre-edge stall id_status", 16'(s_id_status), 16'b0000);
    check("pre-edge stall hazard id_valid=0", 16'(s_hazard), 16'h0);
    tick();
    check_state("update 1001", 4'b1001, 1);

    @(negedge clk);
    set_exe(1'b1, 1'b0, 4'b0110, 1'b0, 1'b0);
    tick();
    check_state("exe_s=0", 4'b1001, 1);

    // flush / freeze / both all suppress the write
    @(negedge clk);
    set_exe(1'b1, 1'b1, 4'b0100, 1'b0, 1'b1);
    #1;
    check("flush fwd id_status", 16'(f_id_status), 16'b1001);
    tick();
    check_state("flush", 4'b1001, 1);

    @(negedge clk);
    set_exe(1'b1, 1'b1, 4'b0100, 1'b1, 1'b0);
    #1;
    check("freeze fwd id_status", 16'(f_id_status), 16'b0100);
    tick();
    check_state("freeze", 4'b1001, 1);

    @(negedge clk);
    set_exe(1'b1, 1'b1, 4'b0100, 1'b1, 1'b1);
    tick();
    check_state("freeze+flush", 4'b1001, 1);

    @(negedge clk);
    set_exe(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    tick();
    check_state("update 0001", 4'b0001, 2);

    // Forwarding vs hazard, checked combinationally within one low phase
    @(negedge clk);
    set_exe(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    id_valid = 1'b1;
    id_cond  = COND_EQ;
    #1;
    check("fwd EQ id_status",   16'(f_id_status), 16'b0000);
    check("fwd EQ hazard",      16'(f_hazard),    16'h0);
    check("stall EQ id_status", 16'(s_id_status), 16'b0001);
    check("stall EQ hazard",    16'(s_hazard),    16'h1);
    id_cond = COND_AL;
    #1;
    check("stall AL hazard", 16'(s_hazard), 16'h0);
    id_cond  = COND_EQ;
    id_valid = 1'b0;
    #1;
    check("stall id_valid=0 hazard", 16'(s_hazard), 16'h0);
    id_valid = 1'b1;
    freeze   = 1'b1;
    #1;
    check("stall freeze hazard", 16'(s_hazard), 16'h1);
    freeze = 1'b0;
    flush  = 1'b1;
    #1;
    check("stall flush hazard", 16'(s_hazard), 16'h0);
    check("fwd flush id_status", 16'(f_id_status), 16'b0001);
    exe_valid = 1'b0;
    flush     = 1'b0;
    tick();
    check_state("after hazard probe", 4'b0001, 2);

    // Async reset in the middle of an update cycle
    @(negedge clk);
    set_exe(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
    id_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_state("mid-update reset", 4'b0000, 0);
    check("mid-update reset fwd id_status", 16'(f_id_status), 16'h0);

    // 17 back-to-back updates after release; 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst = 1'b0;
      pat = status_t'((i * 5 + 3) % 16);
      set_exe(1'b1, 1'b1, pat, 1'b0, 1'b0);
      tick();
      check_state($sformatf("burst %0d", i), pat, i + 1);
    end
    check("burst final stall cnt", 16'(s_cnt), 16'd1);
    check("burst final fwd cnt",   f_cnt,      16'd17);

    @(negedge clk);
    set_exe(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
